// File: rtl/sample_seq_checker.sv
// rtl/sample_seq_checker.sv - sequence-number checker for the slow-domain sample stream
module sample_seq_checker #(
    parameter int DATA_W  = 64,
    parameter int CNT_W   = 16,
    parameter int MAX_GAP = 8,
    parameter int GAP_W   = $clog2(MAX_GAP + 1)
) (
    input  logic              slow_clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              synced_o,
    output logic [CNT_W-1:0]  captured_cnt_o,
    output logic [CNT_W-1:0]  missed_cnt_o,
    output logic [CNT_W-1:0]  dup_cnt_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [GAP_W-1:0]  last_gap_o,
    output logic [1:0]        event_o,
    output logic              event_vld_o
);

    typedef enum logic {
        ST_UNSYNC = 1'b0,
        ST_SYNC   = 1'b1
    } state_t;

    localparam logic [1:0] EV_OK  = 2'd0;
    localparam logic [1:0] EV_GAP = 2'd1;
    localparam logic [1:0] EV_DUP = 2'd2;
    localparam logic [1:0] EV_ERR = 2'd3;

    // Wide enough that adding a gap to a full counter cannot wrap before the saturation test.
    localparam int SUM_W = ((CNT_W > GAP_W) ? CNT_W : GAP_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic [CNT_W-1:0]  captured_q, captured_d;
    logic [CNT_W-1:0]  missed_q, missed_d;
    logic [CNT_W-1:0]  dup_q, dup_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [GAP_W-1:0]  last_gap_q, last_gap_d;
    logic [1:0]        event_q, event_d;
    logic              event_vld_q, event_vld_d;

    logic [DATA_W-1:0] delta;
    logic [GAP_W-1:0]  gap;
    logic [SUM_W-1:0]  missed_sum;
    logic              in_gap;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Modulo distance from the expected value; a wrap from all-ones to zero is delta 0.
    assign delta      = data_i - exp_q;
    assign in_gap     = (delta != '0) && (delta <= DATA_W'(MAX_GAP));
    assign gap        = delta[GAP_W-1:0];
    assign missed_sum = SUM_W'(missed_q) + SUM_W'(gap);

    // State and statistics registers; rst and clear_i both drop any sample of that cycle.
    always_ff @(posedge slow_clk) begin
        if (rst || clear_i) begin
            state_q     <= ST_UNSYNC;
            exp_q       <= '0;
            last_q      <= '0;
            captured_q  <= '0;
            missed_q    <= '0;
            dup_q       <= '0;
            err_q       <= '0;
            last_gap_q  <= '0;
            event_q     <= EV_OK;
            event_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            last_q      <= last_d;
            captured_q  <= captured_d;
            missed_q    <= missed_d;
            dup_q       <= dup_d;
            err_q       <= err_d;
            last_gap_q  <= last_gap_d;
            event_q     <= event_d;
            event_vld_q <= event_vld_d;
        end
    end

    // Classify each valid sample and compute next state, counters and event.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        last_d      = last_q;
        captured_d  = captured_q;
        missed_d    = missed_q;
        dup_d       = dup_q;
        err_d       = err_q;
        last_gap_d  = last_gap_q;
        event_d     = event_q;
        event_vld_d = 1'b0;

        if (valid_i) begin
            captured_d  = sat_inc(captured_q);
            event_vld_d = 1'b1;
            last_d      = data_i;
            exp_d       = data_i + 1'b1;
            case (state_q)
                ST_UNSYNC: begin
                    state_d    = ST_SYNC;
                    event_d    = EV_OK;
                    last_gap_d = '0;
                end
                ST_SYNC: begin
                    if (delta == '0) begin
                        event_d    = EV_OK;
                        last_gap_d = '0;
                    end else if (in_gap) begin
                        event_d    = EV_GAP;
                        last_gap_d = gap;
                        missed_d   = (missed_sum > SUM_W'(CNT_MAX)) ? CNT_MAX
                                                                    : missed_sum[CNT_W-1:0];
                    end else if (data_i == last_q) begin
                        // A repeat keeps the window where it was.
                        event_d = EV_DUP;
                        dup_d   = sat_inc(dup_q);
                        last_d  = last_q;
                        exp_d   = exp_q;
                    end else begin
                        // Out-of-window value: count it and resync on it.
                        event_d = EV_ERR;
                        err_d   = sat_inc(err_q);
                    end
                end
                default: state_d = ST_UNSYNC;
            endcase
        end
    end

    assign synced_o       = (state_q == ST_SYNC);
    assign captured_cnt_o = captured_q;
    assign missed_cnt_o   = missed_q;
    assign dup_cnt_o      = dup_q;
    assign err_cnt_o      = err_q;
    assign last_gap_o     = last_gap_q;
    assign event_o        = event_q;
    assign event_vld_o    = event_vld_q;

endmodule
